user_au_iir1_mc: RTL and testbench

Parametrised, time-multiplexed first-order IIR filter for the audio user domain. It supersedes the single-channel LPF stage. One arithmetic datapath serves NumChannels independent channels, with per-channel state, selectable low-pass or high-pass mode, output saturation, bypass and state clear. It sits inside a filter cascade wrapper between valid/ready audio stages and passes the channel tag through with each sample.

---
 rtl/user_au_iir1_mc.sv | 194 +++++++++++++++++++
 tb/tb_user_au_iir1_mc.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/user_au_iir1_mc.sv
// -----------------------------------------------------------------------------
// user_au_iir1_mc
// Time-multiplexed first-order IIR filter (low-pass / high-pass) for the audio
// user domain. A single arithmetic datapath serves NumChannels independent
// channel states. Each sample goes through IDLE -> CALC -> OUT, so at most one
// sample is accepted every three cycles.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   data_i, chan_i     input sample (signed) and its channel tag
//   valid_i, ready_o   input handshake
//   data_o, chan_o     filtered sample and its channel tag (registered)
//   valid_o, ready_i   output handshake
//   decay_i            unsigned decay coefficient, clamped to unity
//   mode_i             0 = low-pass, 1 = high-pass
//   bypass_i           pass the captured sample through unchanged
//   clear_i            zero every channel state on the next edge
// -----------------------------------------------------------------------------
module user_au_iir1_mc #(
    parameter int DataWidth   = 32,
    parameter int CoefWidth   = 11,
    parameter int CoefFrac    = 10,
    parameter int NumChannels = 2,
    localparam int ChanWidth  = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic signed [DataWidth-1:0] data_i,
    input  logic [ChanWidth-1:0]        chan_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    output logic signed [DataWidth-1:0] data_o,
    output logic [ChanWidth-1:0]        chan_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    input  logic [CoefWidth-1:0]        decay_i,
    input  logic                        mode_i,
    input  logic                        bypass_i,
    input  logic                        clear_i
);

    localparam int ProdWidth = DataWidth + CoefWidth + 2;
    localparam int LpWidth   = DataWidth + 2;
    localparam logic [CoefWidth-1:0] Unity = CoefWidth'(1 << CoefFrac);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_OUT
    } state_e;

    state_e state_q, state_d;

    logic signed [DataWidth-1:0] x_q;
    logic [ChanWidth-1:0]        chan_q;
    logic signed [DataWidth-1:0] res_q;
    logic signed [DataWidth-1:0] wr_q;
    logic                        wen_q;
    logic signed [DataWidth-1:0] st_q [NumChannels];

    logic signed [DataWidth-1:0] s;
    logic                        in_range;
    logic                        byp;
    logic [CoefWidth-1:0]        dc;
    logic signed [DataWidth:0]   d;
    logic signed [ProdWidth-1:0] p;
    logic signed [LpWidth-1:0]   lp_w;
    logic signed [LpWidth-1:0]   hp_w;
    logic signed [DataWidth-1:0] lp_sat;
    logic signed [DataWidth-1:0] hp_sat;
    logic signed [DataWidth-1:0] result;
    logic signed [DataWidth-1:0] wr_val;

    // Clamp a DataWidth+2 value into the DataWidth signed range: in range
    // exactly when the three top bits agree.
    function automatic logic signed [DataWidth-1:0] sat(input logic signed [LpWidth-1:0] v);
        if ((v[LpWidth-1:DataWidth-1] == 3'b000) || (v[LpWidth-1:DataWidth-1] == 3'b111)) begin
            return v[DataWidth-1:0];
        end else if (v[LpWidth-1]) begin
            return {1'b1, {(DataWidth-1){1'b0}}};
        end else begin
            return {1'b0, {(DataWidth-1){1'b1}}};
        end
    endfunction

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        valid_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                state_d = ST_OUT;
            end
            ST_OUT: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ----------------------------------------------------------- datapath
    // The tag is matched against every channel index rather than used as a
    // direct index, so out-of-range tags never address the state array.
    always_comb begin
        s        = '0;
        in_range = 1'b0;
        for (int unsigned i = 0; i < NumChannels; i++) begin
            if (chan_q == ChanWidth'(i)) begin
                in_range = 1'b1;
                s        = st_q[i];
            end
        end
        byp    = bypass_i | ~in_range;
        dc     = (decay_i > Unity) ? Unity : decay_i;
        d      = {s[DataWidth-1], s} - {x_q[DataWidth-1], x_q};
        p      = ProdWidth'($signed({1'b0, dc})) * ProdWidth'(d);
        // |p >>> CoefFrac| <= 2**DataWidth, so truncation to LpWidth is exact.
        lp_w   = LpWidth'(x_q) + LpWidth'(p >>> CoefFrac);
        lp_sat = sat(lp_w);
        hp_w   = LpWidth'(x_q) - LpWidth'(lp_sat);
        hp_sat = sat(hp_w);
        result = byp ? x_q : (mode_i ? hp_sat : lp_sat);
        wr_val = byp ? x_q : lp_sat;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q    <= '0;
            chan_q <= '0;
            res_q  <= '0;
            wr_q   <= '0;
            wen_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (valid_i) begin
                        x_q    <= data_i;
                        chan_q <= chan_i;
                    end
                end
                ST_CALC: begin
                    res_q <= result;
                    wr_q  <= wr_val;
                    wen_q <= in_range;
                end
                default: begin
                end
            endcase
        end
    end

    // Channel state: clear has priority over the write on output handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NumChannels; i++) begin
                st_q[i] <= '0;
            end
        end else if (clear_i) begin
            for (int unsigned i = 0; i < NumChannels; i++) begin
                st_q[i] <= '0;
            end
        end else if ((state_q == ST_OUT) && ready_i && wen_q) begin
            for (int unsigned i = 0; i < NumChannels; i++) begin
                if (chan_q == ChanWidth'(i)) begin
                    st_q[i] <= wr_q;
                end
            end
        end
    end

    assign data_o = res_q;
    assign chan_o = chan_q;

endmodule

// File: tb/tb_user_au_iir1_mc.sv
// -----------------------------------------------------------------------------
// tb_user_au_iir1_mc
// Self-checking bench for user_au_iir1_mc (DataWidth=16, NumChannels=3, so
// tag 3 is out of range). Directed cases followed by randomized traffic, all
// compared against an integer reference model of the filter equations.
// -----------------------------------------------------------------------------
module tb_user_au_iir1_mc;

    localparam int DW = 16;
    localparam int CW = 11;
    localparam int CF = 10;
    localparam int NC = 3;
    localparam int CHW = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic signed [DW-1:0] data_i;
    logic [CHW-1:0]       chan_i;
    logic                 valid_i;
    logic                 ready_o;
    logic signed [DW-1:0] data_o;
    logic [CHW-1:0]       chan_o;
    logic                 valid_o;
    logic                 ready_i;
    logic [CW-1:0]        decay_i;
    logic                 mode_i;
    logic                 bypass_i;
    logic                 clear_i;

    int checks = 0;
    int failures = 0;
    longint ms [NC];
    longint last_out;

    user_au_iir1_mc #(
        .DataWidth  (DW),
        .CoefWidth  (CW),
        .CoefFrac   (CF),
        .NumChannels(NC)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .data_i  (data_i),
        .chan_i  (chan_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .chan_o  (chan_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .decay_i (decay_i),
        .mode_i  (mode_i),
        .bypass_i(bypass_i),
        .clear_i (clear_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint clamp(input longint v);
        longint hi = (longint'(1) <<< (DW - 1)) - 1;
        longint lo = -(longint'(1) <<< (DW - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic longint floor_div(input longint a, input longint b);
        longint q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    task automatic zero_model();
        for (int i = 0; i < NC; i++) ms[i] = 0;
    endtask

    // One full transaction: accept, latency, optional stall, handshake.
    task automatic send(input longint x, input int ch, input int dec, input bit md,
                        input bit byp, input int stall, input bit clr_at_hs);
        bit     in_rng;
        longint s, dcl, lp, hp, exp_out, new_st;
        longint obs_d;
        in_rng  = (ch < NC);
        s       = in_rng ? ms[ch] : 0;
        dcl     = (dec > (1 << CF)) ? (1 << CF) : dec;
        lp      = clamp(x + floor_div(dcl * (s - x), longint'(1) << CF));
        hp      = clamp(x - lp);
        exp_out = (byp || !in_rng) ? x : (md ? hp : lp);
        new_st  = (byp || !in_rng) ? x : lp;

        @(negedge clk);
        data_i   = DW'(x);
        chan_i   = CHW'(ch);
        decay_i  = CW'(dec);
        mode_i   = md;
        bypass_i = byp;
        valid_i  = 1'b1;
        check("idle_ready", ready_o, 1);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        check("calc_valid", valid_o, 0);
        check("calc_ready", ready_o, 0);
        @(posedge clk);
        #1;
        check("lat_valid", valid_o, 1);
        obs_d = longint'(data_o);
        check("data", obs_d, exp_out);
        check("chan", longint'(chan_o), longint'(ch));
        for (int k = 0; k < stall; k++) begin
            @(posedge clk);
            #1;
            check("hold_valid", valid_o, 1);
            check("hold_ready", ready_o, 0);
            check("hold_data", longint'(data_o), obs_d);
        end
        @(negedge clk);
        ready_i = 1'b1;
        clear_i = clr_at_hs;
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        clear_i = 1'b0;
        check("post_valid", valid_o, 0);
        check("post_ready", ready_o, 1);
        if (clr_at_hs) zero_model();
        else if (in_rng) ms[ch] = new_st;
        last_out = obs_d;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        zero_model();
    endtask

    initial begin
        rst_n    = 1'b0;
        data_i   = '0;
        chan_i   = '0;
        valid_i  = 1'b0;
        ready_i  = 1'b0;
        decay_i  = '0;
        mode_i   = 1'b0;
        bypass_i = 1'b0;
        clear_i  = 1'b0;
        zero_model();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready_o, 1);
        check("rst_valid", valid_o, 0);
        check("rst_data", longint'(data_o), 0);
        check("rst_chan", longint'(chan_o), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // LPF step response
        send(1024, 0, 512, 0, 0, 0, 0); check("lpf_step1", last_out, 512);
        send(1024, 0, 512, 0, 0, 0, 0); check("lpf_step2", last_out, 768);
        send(1024, 0, 512, 0, 0, 0, 0); check("lpf_step3", last_out, 896);

        // channel independence
        pulse_clear();
        send(1024, 0, 512, 0, 0, 0, 0); check("indep_c0a", last_out, 512);
        send(1024, 1, 512, 0, 0, 0, 0); check("indep_c1", last_out, 512);
        send(1024, 0, 512, 0, 0, 0, 0); check("indep_c0b", last_out, 768);

        // HPF and negative rounding
        pulse_clear();
        send(1024, 0, 512, 1, 0, 0, 0); check("hpf1", last_out, 512);
        send(1024, 0, 512, 1, 0, 0, 0); check("hpf2", last_out, 256);
        pulse_clear();
        send(-3, 0, 512, 0, 0, 0, 0);

        // saturation, decay clamp
        send(32767, 0, 0, 0, 1, 0, 0);
        send(-32768, 0, 1024, 1, 0, 0, 0); check("sat_hpf", last_out, -32768);
        send(-32768, 0, 2047, 1, 0, 0, 0); check("sat_clamp", last_out, -32768);

        // decay 0 passthrough, out-of-range tag
        send(100, 1, 0, 0, 0, 0, 0);  check("dc0_lpf", last_out, 100);
        send(100, 1, 0, 1, 0, 0, 0);  check("dc0_hpf", last_out, 0);
        send(-500, 3, 512, 0, 0, 0, 0); check("oor_pass", last_out, -500);

        // backpressure with clear at the handshake
        send(1024, 0, 512, 0, 0, 10, 1);
        send(1024, 0, 512, 0, 0, 0, 0); check("after_clear", last_out, 512);

        // bypass
        send(777, 0, 512, 0, 1, 0, 0); check("bypass", last_out, 777);
        send(777, 0, 512, 0, 0, 0, 0); check("unbypass", last_out, 777);

        // reset while in CALC
        @(negedge clk);
        data_i  = DW'(100);
        chan_i  = '0;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("rstcalc_valid", valid_o, 0);
        check("rstcalc_ready", ready_o, 1);
        check("rstcalc_data", longint'(data_o), 0);
        zero_model();
        @(negedge clk);
        rst_n = 1'b1;
        send(1024, 0, 512, 0, 0, 0, 0); check("rst_zeroed", last_out, 512);

        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            logic [15:0] r;
            longint x;
            int dec;
            r = 16'($urandom);
            case ($urandom_range(0, 7))
                0: x = 32767;
                1: x = -32768;
                default: x = longint'($signed(r));
            endcase
            case ($urandom_range(0, 5))
                0: dec = 0;
                1: dec = 1024;
                2: dec = int'($urandom_range(1025, 2047));
                default: dec = int'($urandom_range(0, 1023));
            endcase
            send(x, int'($urandom_range(0, 3)), dec, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 31) == 0) pulse_clear();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
